// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU control sequencer: FSM states, ALU op codes,
// instruction class encodings and the registered control bundle driven during EXECUTE.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALTED
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    localparam logic [2:0] CLS_LDI = 3'b100;
    localparam logic [2:0] CLS_BZ  = 3'b101;
    localparam logic [2:0] CLS_BNE = 3'b110;
    localparam logic [2:0] CLS_SYS = 3'b111;

    localparam logic [5:0] HALT_IMM = 6'h3F;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_Z,
        BR_NE,
        BR_JMP,
        BR_HALT
    } br_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_immediate;
        logic       alu_zero_store;
        logic       alu_halt;
        logic [3:0] rf_rd_addr;
        logic       rf_wr_en;
        logic [3:0] rf_wr_addr;
        logic       rf_wr_sel;
        logic [7:0] imm_value;
        logic       flag_upd;
        br_t        br;
        logic [5:0] offset;
    } ctl_t;

    // Quiescent controls: ALU forced to NOOP, no register write.
    function automatic ctl_t ctl_idle();
        ctl_t c;
        c          = '0;
        c.alu_halt = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_decoder.sv
// Combinational decode of a 9-bit instruction word into ALU, register-file and branch controls.
// Zero latency; no flow control.
module seq_decoder
    import alu_ctrl_pkg::*;
(
    input  logic [8:0] i_ir,
    output ctl_t       o_ctl
);

    always_comb begin
        o_ctl        = ctl_idle();
        o_ctl.alu_op = OP_AND;
        o_ctl.offset = i_ir[5:0];
        if (!i_ir[8]) begin
            o_ctl.alu_op         = i_ir[7:5];
            o_ctl.alu_zero_store = i_ir[4];
            o_ctl.alu_halt       = 1'b0;
            o_ctl.rf_rd_addr     = i_ir[3:0];
            o_ctl.rf_wr_en       = 1'b1;
            o_ctl.rf_wr_addr     = {3'b000, i_ir[4]};
            o_ctl.flag_upd       = 1'b1;
        end else begin
            case (i_ir[8:6])
                CLS_LDI: begin
                    o_ctl.imm_value     = {2'b00, i_ir[5:0]};
                    o_ctl.rf_wr_en      = 1'b1;
                    o_ctl.rf_wr_sel     = 1'b1;
                    o_ctl.alu_immediate = 1'b1;
                end
                CLS_BZ:  o_ctl.br = BR_Z;
                CLS_BNE: o_ctl.br = BR_NE;
                default: o_ctl.br = (i_ir[5:0] == HALT_IMM) ? BR_HALT : BR_JMP;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Fetch/decode/execute sequencer driving the 8-bit ALU and register file, 3 cycles per instruction.
// Controls are registered and live only in EXECUTE; start is ignored while busy.
// Optional macro SEQ_INSTR_COUNT_EN builds a saturating retired-instruction counter.
module alu_ctrl_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int RF_AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [8:0]       imem_data,
    output logic [2:0]       alu_op,
    output logic             alu_immediate,
    output logic             alu_zero_store,
    output logic             alu_halt,
    input  logic             alu_zero,
    input  logic             alu_parity,
    input  logic             alu_ne,
    output logic [RF_AW-1:0] rf_rd_addr,
    output logic             rf_wr_en,
    output logic [RF_AW-1:0] rf_wr_addr,
    output logic             rf_wr_sel,
    output logic [7:0]       imm_value,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             done,
    output logic [15:0]      instr_count
);

    state_t          r_state;
    ctl_t            r_ctl;
    logic [PC_W-1:0] r_pc;
    logic            r_flag_z;
    logic            r_flag_p;
    logic            r_flag_ne;
    logic            r_busy;
    logic            r_done;

    ctl_t            w_dec;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_br;
    logic            w_start_ok;
    logic            w_unused_parity;

    seq_decoder u_dec (
        .i_ir  (imem_data),
        .o_ctl (w_dec)
    );

    assign w_offset   = {{(PC_W-6){r_ctl.offset[5]}}, r_ctl.offset};
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_pc_br    = r_pc + w_offset;
    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_HALTED);
    // Parity is latched alongside the other flags but no branch condition consumes it yet.
    assign w_unused_parity = r_flag_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ctl     <= ctl_idle();
            r_pc      <= '0;
            r_flag_z  <= 1'b0;
            r_flag_p  <= 1'b0;
            r_flag_ne <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (w_start_ok) begin
                        r_state   <= ST_FETCH;
                        r_pc      <= '0;
                        r_flag_z  <= 1'b0;
                        r_flag_p  <= 1'b0;
                        r_flag_ne <= 1'b0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_ctl   <= w_dec;
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    r_ctl   <= ctl_idle();
                    r_state <= ST_FETCH;
                    if (r_ctl.flag_upd) begin
                        r_flag_z  <= alu_zero;
                        r_flag_p  <= alu_parity;
                        r_flag_ne <= alu_ne;
                    end
                    case (r_ctl.br)
                        BR_Z:    r_pc <= r_flag_z  ? w_pc_br : w_pc_inc;
                        BR_NE:   r_pc <= r_flag_ne ? w_pc_br : w_pc_inc;
                        BR_JMP:  r_pc <= w_pc_br;
                        BR_HALT: begin
                            r_state <= ST_HALTED;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                        default: r_pc <= w_pc_inc;
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SEQ_INSTR_COUNT_EN
    logic [15:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_start_ok) begin
            r_instr_count <= '0;
        end else if (r_state == ST_EXECUTE && r_instr_count != 16'hFFFF) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = '0;
`endif

    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign busy           = r_busy;
    assign done           = r_done;
    assign alu_op         = r_ctl.alu_op;
    assign alu_immediate  = r_ctl.alu_immediate;
    assign alu_zero_store = r_ctl.alu_zero_store;
    assign alu_halt       = r_ctl.alu_halt;
    assign rf_rd_addr     = RF_AW'(r_ctl.rf_rd_addr);
    assign rf_wr_en       = r_ctl.rf_wr_en;
    assign rf_wr_addr     = RF_AW'(r_ctl.rf_wr_addr);
    assign rf_wr_sel      = r_ctl.rf_wr_sel;
    assign imm_value      = r_ctl.imm_value;

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Fetch/decode/execute sequencer that drives the 8-bit ALU's control inputs: op_code, immediate, zero_store and halt.
- Fetches 9-bit instructions from instruction memory and decodes them into ALU and register-file controls.
- Latches the ALU's zero, parity and not-equal flags and uses them to resolve branches.
- Sits between instruction memory, the register file and the ALU; it is the control end of the ALU interface.

Parameters:
- PC_W, 10, program counter width; instruction memory depth is 2^PC_W.
- RF_AW, 4, register-file address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins execution at pc=0.
- imem_addr  out  PC_W  instruction fetch address.
- imem_data  in  9  instruction word; valid the cycle after imem_addr is driven (1-cycle latency).
- alu_op  out  3  ALU op_code.
- alu_immediate  out  1  ALU immediate select.
- alu_zero_store  out  1  ALU zero_store select (0: result=R0, 1: result=R1 path).
- alu_halt  out  1  forces the ALU to NOOP.
- alu_zero, alu_parity, alu_ne  in  1 each  combinational flags from the ALU.
- rf_rd_addr  out  RF_AW  register read address; supplies ALU input_1. R0 always supplies input_0.
- rf_wr_en  out  1  register write strobe.
- rf_wr_addr  out  RF_AW  write address.
- rf_wr_sel  out  1  write data select; 0 = ALU result, 1 = imm_value.
- imm_value  out  8  zero-extended immediate.
- pc  out  PC_W  current program counter.
- busy  out  1  high from start until halt.
- done  out  1  high in HALTED until the next start.
- instr_count  out  16  retired-instruction count; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State returns to IDLE from any state; pc=0; latched flags=0.
  - All outputs 0, except alu_halt=1.
  - An in-flight instruction is abandoned with no register write.
- States: IDLE, FETCH, DECODE, EXECUTE, HALTED.
- IDLE: start -> FETCH with pc=0.
- FETCH: imem_addr=pc -> DECODE.
- DECODE: latch imem_data into IR -> EXECUTE.
- EXECUTE: controls are driven from IR for exactly one cycle, then -> FETCH or HALTED.
- Throughput: 3 cycles per instruction.
- Outside EXECUTE: alu_halt=1 and rf_wr_en=0.
- Instruction encoding, IR[8]=0, ALU class:
  - alu_op=IR[7:5], alu_zero_store=IR[4], rf_rd_addr=IR[3:0].
  - rf_wr_addr = IR[4] ? 1 : 0; rf_wr_en=1, rf_wr_sel=0; alu_halt=0.
  - alu_zero, alu_parity, alu_ne are latched at the end of EXECUTE.
  - pc+1.
- IR[8:6]=3'b100, LDI: imm_value={2'b0,IR[5:0]}, rf_wr_addr=0, rf_wr_sel=1, rf_wr_en=1, alu_immediate=1; flags unchanged; pc+1.
- IR[8:6]=3'b101, BZ: if latched zero flag, pc = pc + sext(IR[5:0]); else pc+1.
- IR[8:6]=3'b110, BNE: same as BZ, using the latched not-equal flag.
- IR[8:6]=3'b111:
  - IR[5:0]=6'h3F is HALT -> HALTED; pc holds; alu_halt=1.
  - Any other value is JMP: pc = pc + sext(IR[5:0]).
- Branches and LDI keep alu_halt=1, so the ALU result is 0 and the ALU flags are ignored.
- PC arithmetic is modulo 2^PC_W: pc=2^PC_W-1 plus 1 wraps to 0; negative offsets wrap likewise.
- A branch offset of 0 is a legal self-loop.
- start is ignored in FETCH, DECODE and EXECUTE.
- In HALTED, start restarts at pc=0 next cycle: done drops, busy rises, latched flags clear.
- busy = state in {FETCH, DECODE, EXECUTE}.

Optional Feature:
- Macro SEQ_INSTR_COUNT_EN.
- Defined:
  - instr_count increments once per EXECUTE cycle, HALT included.
  - It clears on reset and on an accepted start.
  - It saturates at 16'hFFFF.
- Undefined: instr_count is tied to 0 and no counter flops are built.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXECUTE, HALTED);
  - ALU op_code localparams (AND, OR, ADD, SUB, XOR, SHL, SHR, MOV = 0..7);
  - class encodings (LDI=3'b100, BZ=3'b101, BNE=3'b110, SYS=3'b111);
  - HALT_IMM=6'h3F.
- One sub-module, seq_decoder: pure combinational IR -> control-output decode.
- The FSM, PC, flag latches and counter stay in the top module.

Test Plan:
- Reset and start:
  - Hold rst_n=0 3 cycles -> all outputs 0, alu_halt=1, pc=0.
  - Pulse start -> imem_addr=0 in the next cycle; busy=1.
- LDI then ALU op:
  - Program LDI 5 (9'h105), then ADD R0,R3 (9'h043).
  - -> cycle 3: rf_wr_en=1, rf_wr_sel=1, imm_value=8'h05.
  - -> cycle 6: alu_op=3'b010, rf_rd_addr=3, rf_wr_addr=0, alu_halt=0.
- Taken branch:
  - SUB producing alu_zero=1, then BZ -2 (9'h17E) at pc=1 -> next fetch address 10'h3FF (wraps below 0).
  - With alu_zero=0 -> next fetch address 2.
- PC wrap: non-branch instruction at pc=10'h3FF -> next imem_addr=0.
- Halt and restart:
  - HALT (9'h1FF) -> done=1, busy=0, pc held.
  - start pulsed during EXECUTE is ignored.
  - start in HALTED -> fetch from 0.
- Mid-run reset:
  - rst_n=0 during EXECUTE of an ALU op -> rf_wr_en=0 next cycle, state IDLE.
  - With SEQ_INSTR_COUNT_EN: instr_count=0 after reset, and 3 after LDI, ADD, HALT.
